// File: rtl/jk_walk_pkg.sv
// Shared types and constants for the JK walk driver.
package jk_walk_pkg;

  localparam int JK_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  // {J,K} excitation encodings
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop, asynchronous active-high reset to 0.
module jk_cell
  import jk_walk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= 1'b0;
    end else begin
      unique case ({J, K})
        JK_HOLD: Q <= Q;
        JK_CLR:  Q <= 1'b0;
        JK_SET:  Q <= 1'b1;
        JK_TGL:  Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_walk_driver.sv
// Walks a row of JK cells to a target word, one bit per cycle.
// Build option: JK_TOGGLE_EN selects toggle excitation for differing bits.
module jk_walk_driver
  import jk_walk_pkg::*;
#(
  parameter int WIDTH = JK_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] target,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [WIDTH-1:0] tgt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tgt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            tgt_q   <= target;
            idx_q   <= '0;
            state_q <= WALK;
          end
        end
        WALK: begin
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only the indexed bit is ever excited, and only if it differs.
  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      logic [1:0] ex;
      ex = JK_HOLD;
      if (state_q == WALK && idx_q == IW'(i) && q[i] != tgt_q[i]) begin
`ifdef JK_TOGGLE_EN
        ex = JK_TGL;
`else
        ex = tgt_q[i] ? JK_SET : JK_CLR;
`endif
      end
      j[i] = ex[1];
      k[i] = ex[0];
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .J   (j[g]),
      .K   (k[g]),
      .Q   (q[g])
    );
  end

endmodule

// File: tb/tb_jk_walk_driver.sv
// Directed bench for jk_walk_driver; expected j/k vectors hand-derived.
module tb_jk_walk_driver;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] target;
  logic       busy;
  logic       done;
  logic [3:0] q;
  logic [3:0] j;
  logic [3:0] k;

  int n_cmp = 0;
  int n_err = 0;

  jk_walk_driver #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .target (target),
    .busy   (busy),
    .done   (done),
    .q      (q),
    .j      (j),
    .k      (k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ej/ek hold the set/reset-build vectors per WALK cycle as
  // {c3,c2,c1,c0}; the toggle build drives j=k on the same bits.
  task automatic run_walk(input string tag, input logic [3:0] tgt,
                          input logic [15:0] ej, input logic [15:0] ek,
                          input logic [3:0] qfin, input bit inject);
    logic [3:0] xj, xk;
    target = tgt;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    target = 4'h0;
    for (int c = 0; c < 4; c++) begin
      xj = ej[c*4 +: 4];
      xk = ek[c*4 +: 4];
`ifdef JK_TOGGLE_EN
      xj = xj | xk;
      xk = xj;
`endif
      chk($sformatf("%s busy c%0d", tag, c), {7'd0, busy}, 8'd1);
      chk($sformatf("%s done c%0d", tag, c), {7'd0, done}, 8'd0);
      chk($sformatf("%s jk c%0d", tag, c), {j, k}, {xj, xk});
      if (inject && c == 1) begin
        load   = 1'b1;
        target = ~tgt;
      end
      tick();
      load   = 1'b0;
      target = 4'h0;
    end
    chk({tag, " done"}, {6'd0, busy, done}, 8'b11);
    chk({tag, " done jk"}, {j, k}, 8'h00);
    chk({tag, " q"}, {4'd0, q}, {4'd0, qfin});
    // load held in DONE must not start a new walk
    load = 1'b1;
    tick();
    load = 1'b0;
    chk({tag, " idle"}, {6'd0, busy, done}, 8'b00);
    chk({tag, " idle q"}, {4'd0, q}, {4'd0, qfin});
    tick();
    chk({tag, " stays idle"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    target = 4'h0;
    #1;
    chk("rst q", {4'd0, q}, 8'h00);
    chk("rst busy/done", {6'd0, busy, done}, 8'b00);
    chk("rst jk", {j, k}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle hold", {busy, done, 2'b00, q}, 8'h00);

    // 0000 -> 1010: excitation only at idx1 and idx3
    run_walk("w1010", 4'b1010, 16'h8020, 16'h0000, 4'b1010, 1'b0);
    // 1010 -> 0101: every bit differs
    run_walk("w0101", 4'b0101, 16'h0401, 16'h8020, 4'b0101, 1'b0);
    // 0101 -> 0110
    run_walk("w0110", 4'b0110, 16'h0020, 16'h0001, 4'b0110, 1'b0);
    // 0110 -> 0110: no excitation at all, still full latency
    run_walk("same", 4'b0110, 16'h0000, 16'h0000, 4'b0110, 1'b0);
    // 0110 -> 1111 with a second request injected mid-walk
    run_walk("w1111", 4'b1111, 16'h8001, 16'h0000, 4'b1111, 1'b1);

    // 1111 -> 0000 interrupted by reset at idx2
    target = 4'b0000;
    load   = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
`ifdef JK_TOGGLE_EN
    chk("rst mid jk", {j, k}, 8'h44);
`else
    chk("rst mid jk", {j, k}, 8'h04);
`endif
    chk("rst mid q", {4'd0, q}, 8'h0C);
    rst = 1'b1;
    #1;
    chk("rst mid q0", {4'd0, q}, 8'h00);
    chk("rst mid flags", {6'd0, busy, done}, 8'b00);
    chk("rst mid jk0", {j, k}, 8'h00);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post rst c%0d", c), {busy, done, 2'b00, q}, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
